// File: rtl/regfile_alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// regfile_alu_sequencer_if
// Bundles every signal around the sequencer: the command/status side facing
// the board FSM, the regfile read/write ports and the ALU operand/result ports.
//   slave  : the sequencer itself (takes commands, drives regfile/ALU controls)
//   master : the environment (issues commands, owns the regfile and the ALU)
// -----------------------------------------------------------------------------
interface regfile_alu_sequencer_if;
    // command side
    logic        start;
    logic [3:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rd;
    logic [15:0] imm;
    logic        use_imm;
    logic [3:0]  rep;
    // status
    logic        busy;
    logic        done;
    logic [3:0]  state;
    logic [4:0]  flags;
    // regfile
    logic [3:0]  rf_addr_a;
    logic [3:0]  rf_addr_b;
    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    // ALU
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_result;
    logic [4:0]  alu_flags;

    modport slave (
        input  start, op, ra, rb, rd, imm, use_imm, rep,
        input  rf_rdata_a, rf_rdata_b, alu_result, alu_flags,
        output busy, done, state, flags,
        output rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata,
        output alu_a, alu_b, alu_opcode
    );

    modport master (
        output start, op, ra, rb, rd, imm, use_imm, rep,
        output rf_rdata_a, rf_rdata_b, alu_result, alu_flags,
        input  busy, done, state, flags,
        input  rf_addr_a, rf_addr_b, rf_we, rf_waddr, rf_wdata,
        input  alu_a, alu_b, alu_opcode
    );
endinterface

// File: rtl/regfile_alu_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_alu_sequencer
// Executes one register-to-register ALU command at a time: latch command,
// read operands, run the ALU, write the result back, optionally repeat N times.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous reset, active low
//   bus    : regfile_alu_sequencer_if.slave (command, status, regfile, ALU)
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start; command registers captured on start
//   FETCH | regfile read addresses driven, operands latched at edge
//   EXEC  | ALU driven from latched operands, result/flags latched
//   WRITE | result written to rd; repeat via FETCH while count > 1
//   DONE  | one-cycle done pulse, back to IDLE
// -----------------------------------------------------------------------------
module regfile_alu_sequencer (
    input  logic                    clk,
    input  logic                    reset,
    regfile_alu_sequencer_if.slave  bus
);
    localparam logic [3:0] CMP_OP  = 4'hB;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_FETCH = 4'd1;
    localparam logic [3:0] S_EXEC  = 4'd2;
    localparam logic [3:0] S_WRITE = 4'd3;
    localparam logic [3:0] S_DONE  = 4'd4;

    logic [3:0]  state_q, state_d;
    logic [3:0]  op_q, ra_q, rb_q, rd_q, cnt_q;
    logic [15:0] imm_q, opa_q, opb_q, res_q;
    logic        use_imm_q;
    logic [4:0]  flags_q;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic; unused codes fall back to IDLE
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = bus.start ? S_FETCH : S_IDLE;
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = (op_q == CMP_OP) ? S_DONE : S_WRITE;
            S_WRITE: state_d = (cnt_q > 4'd1) ? S_FETCH : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs decoded from state and registers only
    always_comb begin
        bus.busy       = (state_q != S_IDLE);
        bus.done       = (state_q == S_DONE);
        bus.state      = state_q;
        bus.flags      = flags_q;
        bus.rf_addr_a  = 4'd0;
        bus.rf_addr_b  = 4'd0;
        bus.rf_we      = 1'b0;
        bus.rf_waddr   = 4'd0;
        bus.rf_wdata   = 16'd0;
        bus.alu_a      = 16'd0;
        bus.alu_b      = 16'd0;
        bus.alu_opcode = 4'd0;
        case (state_q)
            S_FETCH: begin
                bus.rf_addr_a = ra_q;
                bus.rf_addr_b = rb_q;
            end
            S_EXEC: begin
                bus.alu_a      = opa_q;
                bus.alu_b      = opb_q;
                bus.alu_opcode = op_q;
            end
            S_WRITE: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = rd_q;
                bus.rf_wdata = res_q;
            end
            default: ;
        endcase
    end

    // command, operand, result and iteration registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= 4'd0;
            ra_q      <= 4'd0;
            rb_q      <= 4'd0;
            rd_q      <= 4'd0;
            imm_q     <= 16'd0;
            use_imm_q <= 1'b0;
            cnt_q     <= 4'd0;
            opa_q     <= 16'd0;
            opb_q     <= 16'd0;
            res_q     <= 16'd0;
            flags_q   <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    op_q      <= bus.op;
                    ra_q      <= bus.ra;
                    rb_q      <= bus.rb;
                    rd_q      <= bus.rd;
                    imm_q     <= bus.imm;
                    use_imm_q <= bus.use_imm;
                    cnt_q     <= (bus.rep == 4'd0) ? 4'd1 : bus.rep;
                end
                S_FETCH: begin
                    opa_q <= bus.rf_rdata_a;
                    opb_q <= use_imm_q ? imm_q : bus.rf_rdata_b;
                end
                S_EXEC: begin
                    res_q   <= bus.alu_result;
                    flags_q <= bus.alu_flags;
                end
                // count exits at 1, so the decrement never wraps
                S_WRITE: if (cnt_q > 4'd1) cnt_q <= cnt_q - 4'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_alu_sequencer
// Surrounds the sequencer with a 16x16 regfile and a small ALU, then runs the
// directed scenarios followed by random commands against a command-level model.
// ALU opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, B CMP (SUB, flags only).
// Flags: [0] Z, [1] C (carry / borrow), [2] N, [3] V, [4] parity.
// -----------------------------------------------------------------------------
module tb_regfile_alu_sequencer;
    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3,
                           XOR_ = 4'h4, CMP = 4'hB;

    logic clk, reset;
    regfile_alu_sequencer_if bus();

    regfile_alu_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [15:0] rf  [16];
    logic [15:0] mrf [16];
    logic [4:0]  m_flags;
    logic        tb_we;
    logic [3:0]  tb_waddr;
    logic [15:0] tb_wdata;

    function automatic logic [20:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [16:0] w;
        logic        v;
        w = {1'b0, a};
        v = 1'b0;
        case (op)
            ADD: begin
                w = {1'b0, a} + {1'b0, b};
                v = (a[15] == b[15]) && (w[15] != a[15]);
            end
            SUB, CMP: begin
                w = {1'b0, a} - {1'b0, b};
                v = (a[15] != b[15]) && (w[15] != a[15]);
            end
            AND_: w = {1'b0, a & b};
            OR_:  w = {1'b0, a | b};
            XOR_: w = {1'b0, a ^ b};
            default: ;
        endcase
        return {^w[15:0], v, w[15], w[16], (w[15:0] == 16'd0), w[15:0]};
    endfunction

    assign {bus.alu_flags, bus.alu_result} = alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);
    assign bus.rf_rdata_a = rf[bus.rf_addr_a];
    assign bus.rf_rdata_b = rf[bus.rf_addr_b];

    always @(posedge clk) begin
        if (bus.rf_we)  rf[bus.rf_waddr] <= bus.rf_wdata;
        else if (tb_we) rf[tb_waddr]     <= tb_wdata;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = v;
        @(negedge clk);
        tb_we = 1'b0;
        mrf[a] = v;
    endtask

    // results of the last run_cmd, for scenario-specific checks
    int last_done_cyc;
    int last_we_first;

    task automatic run_cmd(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rd, input logic [15:0] imm, input logic uimm,
                           input logic [3:0] rep, input bit pester, input string tag);
        logic [15:0] exp_w[$];
        logic [15:0] got_w[$];
        logic [20:0] r;
        int n, exp_done, done_cnt, done_cyc, bad_addr, busy_first, busy_last, idle_busy;
        // command-level model
        n = (rep == 0) ? 1 : int'(rep);
        if (op == CMP) begin
            r = alu_f(op, mrf[ra], uimm ? imm : mrf[rb]);
            m_flags = r[20:16];
            exp_done = 3;
        end else begin
            for (int i = 0; i < n; i++) begin
                r = alu_f(op, mrf[ra], uimm ? imm : mrf[rb]);
                mrf[rd] = r[15:0];
                m_flags = r[20:16];
                exp_w.push_back(r[15:0]);
            end
            exp_done = 3 * n + 1;
        end
        done_cnt = 0; done_cyc = -1; bad_addr = 0;
        busy_first = -1; busy_last = -1; idle_busy = 1; last_we_first = -1;
        @(negedge clk);
        bus.op = op; bus.ra = ra; bus.rb = rb; bus.rd = rd;
        bus.imm = imm; bus.use_imm = uimm; bus.rep = rep; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                idle_busy = bus.busy;
                break;
            end
            if (bus.busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (bus.rf_we) begin
                got_w.push_back(bus.rf_wdata);
                if (last_we_first < 0) last_we_first = c;
                if (bus.rf_waddr != rd) bad_addr++;
            end
            if (pester && c <= 3) begin
                bus.start = 1'b1; bus.rd = rd ^ 4'h1;
            end else if (pester) begin
                bus.start = 1'b0; bus.rd = rd;
            end
        end
        last_done_cyc = done_cyc;
        check({tag, ".done_count"}, done_cnt, 1);
        check({tag, ".done_cycle"}, done_cyc, exp_done);
        check({tag, ".busy_first"}, busy_first, 1);
        check({tag, ".busy_last"},  busy_last, exp_done);
        check({tag, ".idle_busy"},  {31'd0, idle_busy}, 0);
        check({tag, ".write_count"}, got_w.size(), exp_w.size());
        check({tag, ".write_addr"}, bad_addr, 0);
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            check({tag, ".write_data"}, {16'd0, got_w[i]}, {16'd0, exp_w[i]});
        check({tag, ".flags"}, {27'd0, bus.flags}, {27'd0, m_flags});
        check({tag, ".rf_rd"}, {16'd0, rf[rd]}, {16'd0, mrf[rd]});
    endtask

    initial begin
        reset = 1'b0;
        tb_we = 1'b0; tb_waddr = 4'd0; tb_wdata = 16'd0;
        bus.start = 1'b0; bus.op = 4'd0; bus.ra = 4'd0; bus.rb = 4'd0; bus.rd = 4'd0;
        bus.imm = 16'd0; bus.use_imm = 1'b0; bus.rep = 4'd0;
        m_flags = 5'd0;

        // reset state
        #12;
        check("rst.state", {28'd0, bus.state}, 0);
        check("rst.busy",  {31'd0, bus.busy}, 0);
        check("rst.done",  {31'd0, bus.done}, 0);
        check("rst.rf_we", {31'd0, bus.rf_we}, 0);
        check("rst.flags", {27'd0, bus.flags}, 0);
        check("rst.outs",  {bus.rf_addr_a, bus.rf_addr_b, bus.rf_waddr, bus.alu_opcode,
                            bus.rf_wdata | bus.alu_a | bus.alu_b}, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));

        // single ADD
        preload(4'd1, 16'd5);
        preload(4'd2, 16'd3);
        run_cmd(ADD, 4'd1, 4'd2, 4'd3, 16'd0, 1'b0, 4'd0, 1'b0, "add");
        check("add.R3", {16'd0, rf[3]}, 8);
        check("add.we_cycle", last_we_first, 3);
        check("add.done_cyc4", last_done_cyc, 4);

        // accumulate four times
        preload(4'd1, 16'd5);
        preload(4'd2, 16'd3);
        run_cmd(ADD, 4'd1, 4'd2, 4'd1, 16'd0, 1'b0, 4'd4, 1'b0, "acc");
        check("acc.R1", {16'd0, rf[1]}, 17);
        check("acc.done_cyc13", last_done_cyc, 13);

        // compare, flags only
        preload(4'd1, 16'd7);
        preload(4'd2, 16'd7);
        run_cmd(CMP, 4'd1, 4'd2, 4'd2, 16'd0, 1'b0, 4'd3, 1'b0, "cmp");
        check("cmp.Z", {31'd0, bus.flags[0]}, 1);
        check("cmp.done_cyc3", last_done_cyc, 3);
        check("cmp.we_never", last_we_first, -1);

        // immediate with carry out
        preload(4'd1, 16'd1);
        run_cmd(ADD, 4'd1, 4'd9, 4'd4, 16'hFFFF, 1'b1, 4'd0, 1'b0, "imm");
        check("imm.R4", {16'd0, rf[4]}, 0);
        check("imm.C", {31'd0, bus.flags[1]}, 1);

        // start while busy is ignored
        run_cmd(SUB, 4'd2, 4'd1, 4'd5, 16'd0, 1'b0, 4'd0, 1'b1, "ign");
        check("ign.R6_untouched", {16'd0, rf[6]}, {16'd0, mrf[6]});

        // start held through DONE: next command accepted in the IDLE cycle
        begin
            int dc;
            preload(4'd1, 16'd5);
            preload(4'd2, 16'd3);
            @(negedge clk);
            bus.op = ADD; bus.ra = 4'd1; bus.rb = 4'd2; bus.rd = 4'd3;
            bus.use_imm = 1'b0; bus.rep = 4'd0; bus.start = 1'b1;
            dc = 0;
            for (int c = 0; c < 40 && dc == 0; c++) begin
                @(negedge clk);
                if (bus.done) dc = 1;
            end
            check("hold.first_done", dc, 1);
            @(negedge clk);
            check("hold.idle_gap", {31'd0, bus.busy}, 0);
            @(negedge clk);
            check("hold.reaccept", {31'd0, bus.busy}, 1);
            bus.start = 1'b0;
            dc = 0;
            for (int c = 0; c < 40 && dc == 0; c++) begin
                @(negedge clk);
                if (bus.done) dc = 1;
            end
            check("hold.second_done", dc, 1);
            @(negedge clk);
            mrf[3] = 16'd8;
            m_flags = alu_f(ADD, 16'd5, 16'd3) >> 16;
            check("hold.R3", {16'd0, rf[3]}, 8);
        end

        // reset during WRITE
        begin
            int seen_done;
            preload(4'd1, 16'd5);
            preload(4'd2, 16'd3);
            @(negedge clk);
            bus.op = ADD; bus.ra = 4'd1; bus.rb = 4'd2; bus.rd = 4'd1;
            bus.use_imm = 1'b0; bus.rep = 4'd4; bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            repeat (3) @(negedge clk);
            check("rstw.in_write", {31'd0, bus.rf_we}, 1);
            #1 reset = 1'b0;
            #1;
            check("rstw.we_drop", {31'd0, bus.rf_we}, 0);
            check("rstw.state", {28'd0, bus.state}, 0);
            seen_done = 0;
            repeat (2) begin
                @(negedge clk);
                if (bus.done) seen_done = 1;
            end
            reset = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (bus.done || bus.busy) seen_done = 1;
            end
            check("rstw.no_done", seen_done, 0);
            check("rstw.R1_kept", {16'd0, rf[1]}, 5);
            m_flags = 5'd0;
            check("rstw.flags_clr", {27'd0, bus.flags}, 0);
            run_cmd(ADD, 4'd1, 4'd2, 4'd1, 16'd0, 1'b0, 4'd2, 1'b0, "after_rst");
        end

        // random commands
        for (int i = 0; i < 10; i++) begin
            logic [3:0] op;
            case ($urandom_range(0, 5))
                0: op = ADD;
                1: op = SUB;
                2: op = AND_;
                3: op = OR_;
                4: op = XOR_;
                default: op = CMP;
            endcase
            run_cmd(op, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
                    1'($urandom), 4'($urandom_range(0, 5)), 1'b0, "rand");
        end
        for (int i = 0; i < 16; i++)
            check("final.rf", {16'd0, rf[i]}, {16'd0, mrf[i]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_alu_sequencer.md
# regfile_alu_sequencer

Multi-cycle controller that executes one register-to-register ALU command at a time on the 16 x 16-bit register file and the ALU. It latches a command on `start`, reads operands, drives the ALU, writes the result back and pulses `done`, optionally repeating the operation N times for accumulate-style loops. It sits between the top-level FSM/board logic and the regfile/ALU pair, replacing hand-sequenced test FSMs.

## Interface
- `CMP_OP`, 4'hB: ALU opcode that sets flags only (no write-back).
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `start`  in  1  command request; sampled only in IDLE.
- `op`  in  4  ALU opcode, passed through to `alu_opcode`.
- `ra`, `rb`, `rd`  in  4 each  source A, source B, destination register index.
- `imm`  in  16  immediate operand.
- `use_imm`  in  1  1: operand B = `imm`; 0: operand B = R[rb].
- `rep`  in  4  repeat count; 0 is treated as 1.
- `busy`  out  1  high from the cycle after acceptance through DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `state`  out  4  current state encoding (debug / display).
- `flags`  out  5  ALU flags latched from last EXEC.
- `rf_addr_a`, `rf_addr_b`  out  4 each  regfile read addresses.
- `rf_rdata_a`, `rf_rdata_b`  in  16 each  regfile combinational read data.
- `rf_we`  out  1  regfile write enable.
- `rf_waddr`  out  4  regfile write address.
- `rf_wdata`  out  16  regfile write data.
- `alu_a`, `alu_b`  out  16 each  ALU operands.
- `alu_opcode`  out  4  ALU opcode.
- `alu_result`  in  16  ALU result (combinational).
- `alu_flags`  in  5  ALU flags (combinational).

## Operation
- States: IDLE=0, FETCH=1, EXEC=2, WRITE=3, DONE=4; codes 5-15 unreachable, decode to IDLE on next edge.
- IDLE: `start`=1 latches `op`, `ra`, `rb`, `rd`, `imm`, `use_imm`, and count = (`rep`==0 ? 1 : `rep`); go FETCH.
- FETCH: `rf_addr_a`=ra, `rf_addr_b`=rb; at edge latch operand A = `rf_rdata_a`, operand B = use_imm ? imm : `rf_rdata_b`; go EXEC.
- EXEC: `alu_a`/`alu_b`/`alu_opcode` driven from latched values; at edge latch `alu_result` into result register and `alu_flags` into `flags`. If op==CMP_OP go DONE (no write, no repeat); else go WRITE.
- WRITE: `rf_we`=1, `rf_waddr`=rd, `rf_wdata`=result; at edge decrement count; if count before decrement >1 go FETCH, else DONE.
- DONE: `done`=1 for exactly one cycle; go IDLE.
- Repeat re-reads registers each iteration, so ra==rd gives R[rd] = R[rd] op B applied N times.
- All outputs are Moore: decoded from state and internal registers only; no combinational input-to-output path.
- Arithmetic is the ALU's; the sequencer does no math except 4-bit count decrement (never wraps: exits at 1).

## Timing
- Reset (async, immediate): state=IDLE, `busy`=0, `done`=0, `rf_we`=0, `flags`=0, all address/data/operand outputs 0, latched command cleared.
- Reset mid-operation (including during WRITE): `rf_we` drops asynchronously; command abandoned, no `done`.
- Latency: start sampled at edge 0 -> FETCH cycle 1, EXEC 2, WRITE 3, DONE 4 (`done` high in cycle 3N+1 for N iterations); CMP: DONE in cycle 3.
- `busy` high in every non-IDLE state; `start` while busy is ignored, not queued.
- `start` held high across DONE->IDLE: a new command is accepted in the IDLE cycle (one idle cycle between commands minimum).
- Regfile write commits at the rising edge ending WRITE; the following FETCH sees the new value.

## Test plan
- Reset then R1=5, R2=3; start op=ADD, ra=1, rb=2, rd=3, rep=0 -> rf_we one cycle in cycle 3, R3=8, `done` in cycle 4, `busy` cycles 1-4.
- R1=5, R2=3; ADD ra=rd=1, rb=2, rep=4 -> four writes (8, 11, 14, 17), R1=17, `done` in cycle 13.
- R1=7, R2=7; op=CMP_OP -> no rf_we ever, `flags` = ALU flags for 7 vs 7 (Z set), `done` in cycle 3.
- R1=1, use_imm=1, imm=16'hFFFF, ADD, rd=4 -> R4=16'h0000, carry flag set in `flags`.
- Pulse `start` again in cycles 1-3 with different rd -> ignored; only original rd written; single `done`.
- Assert reset=0 during WRITE of a rep=4 command -> `rf_we` 0 immediately, state=0, no `done`; next command after release runs normally.
